// File: rtl/pir_occupancy_if.sv
// Signal bundle between a PIR sensor front end and the occupancy conditioner.
// The master side drives the raw sensor level; the slave side returns the conditioned flags.
interface pir_occupancy_if;
    logic pir_in;
    logic ocupado;
    logic motion_evt;
    logic hold_active;

    modport master (
        output pir_in,
        input  ocupado,
        input  motion_evt,
        input  hold_active
    );

    modport slave (
        input  pir_in,
        output ocupado,
        output motion_evt,
        output hold_active
    );
endinterface

// File: rtl/pir_occupancy.sv
// PIR occupancy conditioner: synchronizer, optional debounce filter, and an
// occupancy FSM with an optional hold timer that stretches ocupado after motion stops.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_VACANT   | no accepted detection and hold timer expired; ocupado=0
// ST_OCCUPIED | accepted detection present; hold timer loaded; ocupado=1
// ST_HOLD     | detection dropped, hold timer counting down; ocupado=1
module pir_occupancy #(
    parameter int SYNC_STAGES     = 1,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int HOLD_CYCLES     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    pir_occupancy_if.slave  bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("pir_occupancy: SYNC_STAGES must be in 1..3");
    end
    if (DEBOUNCE_CYCLES < 0) begin : g_bad_deb
        $error("pir_occupancy: DEBOUNCE_CYCLES must not be negative");
    end
    if (HOLD_CYCLES < 0) begin : g_bad_hold
        $error("pir_occupancy: HOLD_CYCLES must not be negative");
    end

    typedef enum logic [1:0] {
        ST_VACANT   = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   accepted;

    state_e                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   acc_prev_q;
    logic                   evt_q, evt_d;

    // Only sync_q[0] ever looks at the asynchronous sensor pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.pir_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
        assign accepted = sync;
    end else begin : g_deb
        localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

        logic [DW-1:0] cnt_q, cnt_d;
        logic          acc_q, acc_d;

        // Flip on the cycle the disagreement count would reach DEBOUNCE_CYCLES.
        always_comb begin
            cnt_d = '0;
            acc_d = acc_q;
            if (sync != acc_q) begin
                if (cnt_q == CNT_LAST) begin
                    acc_d = sync;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
        end

        assign accepted = acc_q;
    end

    always_comb begin
        state_d = ST_VACANT;
        hold_d  = hold_q;
        evt_d   = accepted & ~acc_prev_q;
        if (accepted) begin
            state_d = ST_OCCUPIED;
            hold_d  = HOLD_LOAD;
        end else if (hold_q != '0) begin
            state_d = ST_HOLD;
            hold_d  = hold_q - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_VACANT;
            hold_q     <= '0;
            acc_prev_q <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            acc_prev_q <= accepted;
            evt_q      <= evt_d;
        end
    end

    assign bus.ocupado     = (state_q != ST_VACANT);
    assign bus.hold_active = (state_q == ST_HOLD);
    assign bus.motion_evt  = evt_q;

endmodule

// File: tb/tb_pir_occupancy.sv
// Directed bench for pir_occupancy: default, debounce-4 and hold-5 instances
// share clock and reset; each scenario drives its own instance.
module tb_pir_occupancy;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pir_occupancy_if if_def ();
    pir_occupancy_if if_deb ();
    pir_occupancy_if if_hold ();

    pir_occupancy u_def (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_def)
    );

    pir_occupancy #(.DEBOUNCE_CYCLES(4)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_deb)
    );

    pir_occupancy #(.HOLD_CYCLES(5)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        if_def.pir_in  = 1'b0;
        if_deb.pir_in  = 1'b0;
        if_hold.pir_in = 1'b0;
        #1;
        vectors++;
        if ({if_def.ocupado, if_def.motion_evt, if_def.hold_active} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_def outputs got %b want 000",
                     {if_def.ocupado, if_def.motion_evt, if_def.hold_active});
        end
        vectors++;
        if ({if_deb.ocupado, if_deb.motion_evt, if_deb.hold_active} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_deb outputs got %b want 000",
                     {if_deb.ocupado, if_deb.motion_evt, if_deb.hold_active});
        end
        vectors++;
        if ({if_hold.ocupado, if_hold.motion_evt, if_hold.hold_active} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold outputs got %b want 000",
                     {if_hold.ocupado, if_hold.motion_evt, if_hold.hold_active});
        end
        #9;
        rst_n = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            vectors++;
            if ({if_def.ocupado, if_def.motion_evt} !== 2'b00) begin
                miscompares++;
                $display("FAIL idle_after_reset cycle %0d got %b want 00",
                         k, {if_def.ocupado, if_def.motion_evt});
            end
        end
    endtask

    task automatic test_default_rise;
        if_def.pir_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++;
            if (if_def.ocupado !== (k >= 2)) begin
                miscompares++;
                $display("FAIL def_rise_ocupado edge %0d got %b want %b", k, if_def.ocupado, k >= 2);
            end
            vectors++;
            if (if_def.motion_evt !== (k == 2)) begin
                miscompares++;
                $display("FAIL def_rise_evt edge %0d got %b want %b", k, if_def.motion_evt, k == 2);
            end
        end
    endtask

    task automatic test_default_fall_rerise;
        if_def.pir_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if ({if_def.ocupado, if_def.motion_evt} !== {k < 2, 1'b0}) begin
                miscompares++;
                $display("FAIL def_fall edge %0d got %b want %b",
                         k, {if_def.ocupado, if_def.motion_evt}, {k < 2, 1'b0});
            end
        end
        if_def.pir_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if ({if_def.ocupado, if_def.motion_evt} !== {k >= 2, k == 2}) begin
                miscompares++;
                $display("FAIL def_rerise edge %0d got %b want %b",
                         k, {if_def.ocupado, if_def.motion_evt}, {k >= 2, k == 2});
            end
        end
        if_def.pir_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_debounce_glitch;
        if_deb.pir_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (if_deb.ocupado !== 1'b0) begin
                miscompares++;
                $display("FAIL deb_glitch_high edge %0d got %b want 0", k, if_deb.ocupado);
            end
        end
        if_deb.pir_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({if_deb.ocupado, if_deb.motion_evt} !== 2'b00) begin
                miscompares++;
                $display("FAIL deb_glitch_after edge %0d got %b want 00",
                         k, {if_deb.ocupado, if_deb.motion_evt});
            end
        end
    endtask

    task automatic test_debounce_pulse;
        if_deb.pir_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({if_deb.ocupado, if_deb.motion_evt} !== {k == 6, k == 6}) begin
                miscompares++;
                $display("FAIL deb_pulse_rise edge %0d got %b want %b",
                         k, {if_deb.ocupado, if_deb.motion_evt}, {k == 6, k == 6});
            end
        end
        if_deb.pir_in = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            vectors++;
            if ({if_deb.ocupado, if_deb.motion_evt} !== {k < 6, 1'b0}) begin
                miscompares++;
                $display("FAIL deb_pulse_fall edge %0d got %b want %b",
                         k, {if_deb.ocupado, if_deb.motion_evt}, {k < 6, 1'b0});
            end
        end
    endtask

    task automatic test_hold_basic;
        if_hold.pir_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active} !== {k >= 2, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_rise edge %0d got %b want %b",
                         k, {if_hold.ocupado, if_hold.hold_active}, {k >= 2, 1'b0});
            end
        end
        if_hold.pir_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active} !== {k <= 6, (k >= 2) && (k <= 6)}) begin
                miscompares++;
                $display("FAIL hold_fall edge %0d got %b want %b",
                         k, {if_hold.ocupado, if_hold.hold_active}, {k <= 6, (k >= 2) && (k <= 6)});
            end
        end
    endtask

    task automatic test_hold_retrigger;
        if_hold.pir_in = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        if_hold.pir_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active} !== {1'b1, k >= 2}) begin
                miscompares++;
                $display("FAIL retrig_pre edge %0d got %b want %b",
                         k, {if_hold.ocupado, if_hold.hold_active}, {1'b1, k >= 2});
            end
        end
        if_hold.pir_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active, if_hold.motion_evt} !== {1'b1, k == 1, k == 2}) begin
                miscompares++;
                $display("FAIL retrig_re edge %0d got %b want %b",
                         k, {if_hold.ocupado, if_hold.hold_active, if_hold.motion_evt},
                         {1'b1, k == 1, k == 2});
            end
        end
        if_hold.pir_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active} !== {k <= 6, (k >= 2) && (k <= 6)}) begin
                miscompares++;
                $display("FAIL retrig_reload edge %0d got %b want %b",
                         k, {if_hold.ocupado, if_hold.hold_active}, {k <= 6, (k >= 2) && (k <= 6)});
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        if_hold.pir_in = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        if_hold.pir_in = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        vectors++;
        if ({if_hold.ocupado, if_hold.hold_active} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_hold_pre got %b want 11", {if_hold.ocupado, if_hold.hold_active});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({if_hold.ocupado, if_hold.hold_active, if_hold.motion_evt} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_hold_async_reset got %b want 000",
                     {if_hold.ocupado, if_hold.hold_active, if_hold.motion_evt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if ({if_hold.ocupado, if_hold.hold_active} !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset_idle edge %0d got %b want 00",
                         k, {if_hold.ocupado, if_hold.hold_active});
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_default_rise();
        test_default_fall_rerise();
        test_debounce_glitch();
        test_debounce_pulse();
        test_hold_basic();
        test_hold_retrigger();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pir_occupancy.md
Name: pir_occupancy

Overview:
- Conditions the raw digital output of a PIR motion sensor and produces a clean, registered room-occupancy flag (ocupado) for the occupancy-control logic.
- Processing chain: input synchronizer, optional debounce filter, optional occupancy hold timer.
- With default parameters, ocupado follows pir_in with a fixed two-clock latency.

Parameters:
- SYNC_STAGES, 1, number of synchronizer flops on pir_in; legal range 1..3.
- DEBOUNCE_CYCLES, 0, consecutive cycles a synchronized level must differ from the accepted level before it is accepted; 0 = filter bypassed.
- HOLD_CYCLES, 0, extra cycles ocupado stays high after accepted detection drops; 0 = no hold.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
- pir_in  input  1  raw PIR sensor output, asynchronous to clk; 1 = motion.
- ocupado  output  1  registered occupancy flag; 1 = occupied.
- motion_evt  output  1  one-cycle pulse on each 0->1 transition of the accepted detection level.
- hold_active  output  1  high while the hold timer is counting down.

Behaviour:
- Reset (rst_n=0, immediate): all synchronizer flops 0; accepted level 0; debounce counter 0; hold counter 0; ocupado=0, motion_evt=0, hold_active=0.
- Synchronizer: chain of SYNC_STAGES flops clocked by clk; sync = last stage. No other logic samples pir_in directly.
- Debounce, DEBOUNCE_CYCLES=0: accepted level = sync (combinational).
- Debounce, DEBOUNCE_CYCLES=N>0:
  - Counter increments each cycle sync != accepted.
  - Counter clears whenever sync == accepted.
  - Accepted flips on the edge where the counter would reach N; counter then clears.
  - Counter width = $clog2(N+1).
  - Glitches shorter than N cycles never change the accepted level.
- Output register (ocupado), updated every edge:
  - accepted=1: ocupado<=1; hold counter<=HOLD_CYCLES.
  - accepted=0, hold counter>0: ocupado<=1; hold counter decrements.
  - accepted=0, hold counter=0: ocupado<=0.
- hold_active = (accepted==0) && (hold counter>0), registered alongside ocupado.
- Re-detection while the hold is running reloads the counter; ocupado never glitches low.
- motion_evt: registered; 1 for exactly one cycle when accepted goes 0->1, including a retrigger during hold. Never high for two consecutive cycles.
- Rise latency: pir_in rising to ocupado=1 = SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges. Defaults give 2 edges.
- Fall latency: SYNC_STAGES + DEBOUNCE_CYCLES + HOLD_CYCLES + 1 edges. Defaults give 2 edges.
- pir_in held constant: ocupado reaches a steady value equal to pir_in and stays there.
- Reset asserted mid-hold or mid-debounce: all state cleared immediately.
- After reset release: ocupado=0 until detection propagates through the full rise latency.
- Parameter legality: SYNC_STAGES outside 1..3 or negative counts are illegal; elaboration stops with $error.

Test Plan:
- Defaults, rst_n low 10 ns then high, pir_in=0 for 20 ns -> ocupado=0, motion_evt=0 throughout.
- Defaults, 10 ns clk, pir_in 0->1 between edges -> ocupado=1 after 2nd rising edge, held; motion_evt=1 for exactly 1 cycle.
- Defaults, pir_in 1->0 -> ocupado=0 after 2nd edge; then pir_in 0->1 -> ocupado=1 after 2 edges with a new motion_evt pulse.
- DEBOUNCE_CYCLES=4: pir_in pulse of 3 cycles -> ocupado stays 0; pulse of 6 cycles -> ocupado=1 at edge 1+4+1=6 after the rise.
- HOLD_CYCLES=5: pir_in 1 then 0 -> ocupado stays 1 for 5 extra cycles with hold_active=1, then 0. Retrigger at hold cycle 3 -> ocupado never drops, motion_evt pulses, counter reloads.
- Reset mid-hold (HOLD_CYCLES=5, rst_n low at hold cycle 2) -> ocupado=0, hold_active=0 immediately, without waiting for a clock edge.
